// File: rtl/tiled_matmul_controller.sv
// Sequences C[R x P] = A[R x K] * B[K x P] over an RP x CP processor grid in
// passes of NxN tiles, issuing buffer instructions and counting tile completions.
module tiled_matmul_controller #(
  parameter int unsigned N                   = 4,
  parameter int unsigned MAX_MATRIX_LENGTH   = 4096,
  parameter int unsigned ROWS_PROCESSORS     = 2,
  parameter int unsigned COLS_PROCESSORS     = 2,
  parameter int unsigned ELEM_BYTES          = 1,
  parameter int unsigned MEMORY_ADDRESS_BITS = 64,
  parameter int unsigned MATRIX_LENGTH_BITS  = $clog2(MAX_MATRIX_LENGTH + 1),
  parameter int unsigned TILE_COUNT_BITS     = $clog2((MAX_MATRIX_LENGTH / N + 1) ** 2 + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MEMORY_ADDRESS_BITS-1:0] a_memory_addr,
  input  logic [MEMORY_ADDRESS_BITS-1:0] b_memory_addr,
  input  logic [MEMORY_ADDRESS_BITS-1:0] c_memory_addr,
  input  logic [MATRIX_LENGTH_BITS-1:0]  rows_input,
  input  logic [MATRIX_LENGTH_BITS-1:0]  inner_input,
  input  logic [MATRIX_LENGTH_BITS-1:0]  cols_input,
  input  logic                           output_by_row_input,
  input  logic                           instruction_valid,
  output logic                           instruction_ready,
  output logic                           done,
  output logic [TILE_COUNT_BITS-1:0]     tiles_completed,
  output logic                           a_input_buffer_instruction_valids [ROWS_PROCESSORS],
  input  logic                           a_input_buffer_instruction_readys [ROWS_PROCESSORS],
  output logic [MEMORY_ADDRESS_BITS-1:0] a_input_buffer_address_inputs    [ROWS_PROCESSORS],
  output logic [MATRIX_LENGTH_BITS-1:0]  a_input_buffer_length_inputs     [ROWS_PROCESSORS],
  output logic [MATRIX_LENGTH_BITS-1:0]  a_input_buffer_repeats_inputs    [ROWS_PROCESSORS],
  output logic                           b_input_buffer_instruction_valids [COLS_PROCESSORS],
  input  logic                           b_input_buffer_instruction_readys [COLS_PROCESSORS],
  output logic [MEMORY_ADDRESS_BITS-1:0] b_input_buffer_address_inputs    [COLS_PROCESSORS],
  output logic [MATRIX_LENGTH_BITS-1:0]  b_input_buffer_length_inputs     [COLS_PROCESSORS],
  output logic [MATRIX_LENGTH_BITS-1:0]  b_input_buffer_repeats_inputs    [COLS_PROCESSORS],
  output logic                           output_buffer_instruction_valids  [ROWS_PROCESSORS][COLS_PROCESSORS],
  input  logic                           output_buffer_instruction_readys  [ROWS_PROCESSORS][COLS_PROCESSORS],
  output logic [MEMORY_ADDRESS_BITS-1:0] output_buffer_address_inputs      [ROWS_PROCESSORS][COLS_PROCESSORS],
  output logic                           output_buffer_by_row_instructions [ROWS_PROCESSORS][COLS_PROCESSORS],
  input  logic                           output_buffer_completed_valids    [ROWS_PROCESSORS][COLS_PROCESSORS],
  output logic                           output_buffer_completed_readys    [ROWS_PROCESSORS][COLS_PROCESSORS]
);

  localparam int unsigned RP  = ROWS_PROCESSORS;
  localparam int unsigned CP  = COLS_PROCESSORS;
  localparam int unsigned MAB = MEMORY_ADDRESS_BITS;
  localparam int unsigned MLB = MATRIX_LENGTH_BITS;
  localparam int unsigned TCB = TILE_COUNT_BITS;
  localparam int unsigned TW  = MLB + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic             launch_q, launch_d;
  logic [MAB-1:0]   a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic [MLB-1:0]   rows_q, rows_d, inner_q, inner_d, cols_q, cols_d;
  logic             by_row_q, by_row_d;
  logic [TW-1:0]    pr_q, pr_d, pc_q, pc_d;
  logic [TCB-1:0]   tiles_q, tiles_d;
  logic             done_q, done_d;
  logic             instr_rdy_q, instr_rdy_d;
  logic             cmp_rdy_q, cmp_rdy_d;
  logic [MLB-1:0]   len_q, len_d, rep_q, rep_d;
  logic             a_vld_q [RP];
  logic             a_vld_d [RP];
  logic [MAB-1:0]   a_addr_q [RP];
  logic [MAB-1:0]   a_addr_d [RP];
  logic             b_vld_q [CP];
  logic             b_vld_d [CP];
  logic [MAB-1:0]   b_addr_q [CP];
  logic [MAB-1:0]   b_addr_d [CP];
  logic             o_vld_q [RP][CP];
  logic             o_vld_d [RP][CP];
  logic [MAB-1:0]   o_addr_q [RP][CP];
  logic [MAB-1:0]   o_addr_d [RP][CP];

  logic [TW-1:0]    tr_tot_c, tc_tot_c, pr_tot_c, pc_tot_c;
  logic [TCB-1:0]   total_c;
  logic             zero_c;

  function automatic logic [TW-1:0] tile_idx(input logic [TW-1:0] pass_idx,
                                             input int unsigned per_pass,
                                             input int unsigned unit);
    return pass_idx * TW'(per_pass) + TW'(unit);
  endfunction

  function automatic logic [MAB-1:0] ab_addr(input logic [MAB-1:0] base,
                                             input logic [TW-1:0]  idx,
                                             input logic [MLB-1:0] k);
    return base + MAB'(idx) * MAB'(N * ELEM_BYTES) * MAB'(k);
  endfunction

  function automatic logic [MAB-1:0] c_addr(input logic [MAB-1:0] base,
                                            input logic [TW-1:0]  tr,
                                            input logic [TW-1:0]  tc,
                                            input logic [MLB-1:0] p);
    return base + (MAB'(tr) * MAB'(N) * MAB'(p) + MAB'(tc) * MAB'(N)) * MAB'(ELEM_BYTES);
  endfunction

  // Job geometry derived from the latched command
  assign tr_tot_c = (TW'(rows_q) + TW'(N - 1)) / TW'(N);
  assign tc_tot_c = (TW'(cols_q) + TW'(N - 1)) / TW'(N);
  assign pr_tot_c = (tr_tot_c + TW'(RP - 1)) / TW'(RP);
  assign pc_tot_c = (tc_tot_c + TW'(CP - 1)) / TW'(CP);
  assign total_c  = TCB'(TCB'(tr_tot_c) * TCB'(tc_tot_c));
  assign zero_c   = (rows_q == '0) || (inner_q == '0) || (cols_q == '0);

  always_comb begin
    logic           load;
    logic           pending;
    logic [TW-1:0]  npr;
    logic [TW-1:0]  npc;
    logic [TCB-1:0] cnt;

    state_d  = state_q;
    launch_d = 1'b0;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    rows_d   = rows_q;
    inner_d  = inner_q;
    cols_d   = cols_q;
    by_row_d = by_row_q;
    pr_d     = pr_q;
    pc_d     = pc_q;
    done_d   = done_q;
    len_d    = len_q;
    rep_d    = rep_q;
    load     = 1'b0;
    pending  = 1'b0;
    npr      = '0;
    npc      = '0;
    cnt      = '0;

    // Each valid drops after its own handshake; anything still held keeps the pass open
    for (int unsigned r = 0; r < RP; r++) begin
      a_vld_d[r]  = a_vld_q[r] && !a_input_buffer_instruction_readys[r];
      a_addr_d[r] = a_addr_q[r];
      pending     = pending | a_vld_d[r];
    end
    for (int unsigned c = 0; c < CP; c++) begin
      b_vld_d[c]  = b_vld_q[c] && !b_input_buffer_instruction_readys[c];
      b_addr_d[c] = b_addr_q[c];
      pending     = pending | b_vld_d[c];
    end
    for (int unsigned r = 0; r < RP; r++) begin
      for (int unsigned c = 0; c < CP; c++) begin
        o_vld_d[r][c]  = o_vld_q[r][c] && !output_buffer_instruction_readys[r][c];
        o_addr_d[r][c] = o_addr_q[r][c];
        pending        = pending | o_vld_d[r][c];
        if (output_buffer_completed_valids[r][c] && cmp_rdy_q) cnt = cnt + TCB'(1);
      end
    end
    tiles_d = tiles_q + cnt;

    case (state_q)
      IDLE, DONE: begin
        if (instruction_valid && instr_rdy_q) begin
          a_base_d = a_memory_addr;
          b_base_d = b_memory_addr;
          c_base_d = c_memory_addr;
          rows_d   = rows_input;
          inner_d  = inner_input;
          cols_d   = cols_input;
          by_row_d = output_by_row_input;
          done_d   = 1'b0;
          tiles_d  = '0;
          launch_d = 1'b1;
          state_d  = IDLE;
        end else if (launch_q) begin
          if (zero_c) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            load    = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!pending) begin
          if (pr_q == pr_tot_c - TW'(1) && pc_q == pc_tot_c - TW'(1)) begin
            state_d = DRAIN;
          end else begin
            load = 1'b1;
            if (pc_q == pc_tot_c - TW'(1)) begin
              npc = '0;
              npr = pr_q + TW'(1);
            end else begin
              npc = pc_q + TW'(1);
              npr = pr_q;
            end
          end
        end
      end
      DRAIN: begin
        if (tiles_d == total_c) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entering a pass: raise every active unit together with its fields
    if (load) begin
      pr_d  = npr;
      pc_d  = npc;
      len_d = inner_q;
      rep_d = MLB'(1);
      for (int unsigned r = 0; r < RP; r++) begin
        a_vld_d[r]  = tile_idx(npr, RP, r) < tr_tot_c;
        a_addr_d[r] = ab_addr(a_base_q, tile_idx(npr, RP, r), inner_q);
      end
      for (int unsigned c = 0; c < CP; c++) begin
        b_vld_d[c]  = tile_idx(npc, CP, c) < tc_tot_c;
        b_addr_d[c] = ab_addr(b_base_q, tile_idx(npc, CP, c), inner_q);
      end
      for (int unsigned r = 0; r < RP; r++) begin
        for (int unsigned c = 0; c < CP; c++) begin
          o_vld_d[r][c]  = (tile_idx(npr, RP, r) < tr_tot_c) && (tile_idx(npc, CP, c) < tc_tot_c);
          o_addr_d[r][c] = c_addr(c_base_q, tile_idx(npr, RP, r), tile_idx(npc, CP, c), cols_q);
        end
      end
    end

    instr_rdy_d = (state_d == IDLE) || (state_d == DONE);
    cmp_rdy_d   = (state_d == ISSUE) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      launch_q    <= 1'b0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      c_base_q    <= '0;
      rows_q      <= '0;
      inner_q     <= '0;
      cols_q      <= '0;
      by_row_q    <= 1'b0;
      pr_q        <= '0;
      pc_q        <= '0;
      tiles_q     <= '0;
      done_q      <= 1'b0;
      instr_rdy_q <= 1'b1;
      cmp_rdy_q   <= 1'b0;
      len_q       <= '0;
      rep_q       <= '0;
      for (int unsigned r = 0; r < RP; r++) begin
        a_vld_q[r]  <= 1'b0;
        a_addr_q[r] <= '0;
      end
      for (int unsigned c = 0; c < CP; c++) begin
        b_vld_q[c]  <= 1'b0;
        b_addr_q[c] <= '0;
      end
      for (int unsigned r = 0; r < RP; r++) begin
        for (int unsigned c = 0; c < CP; c++) begin
          o_vld_q[r][c]  <= 1'b0;
          o_addr_q[r][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      launch_q    <= launch_d;
      a_base_q    <= a_base_d;
      b_base_q    <= b_base_d;
      c_base_q    <= c_base_d;
      rows_q      <= rows_d;
      inner_q     <= inner_d;
      cols_q      <= cols_d;
      by_row_q    <= by_row_d;
      pr_q        <= pr_d;
      pc_q        <= pc_d;
      tiles_q     <= tiles_d;
      done_q      <= done_d;
      instr_rdy_q <= instr_rdy_d;
      cmp_rdy_q   <= cmp_rdy_d;
      len_q       <= len_d;
      rep_q       <= rep_d;
      for (int unsigned r = 0; r < RP; r++) begin
        a_vld_q[r]  <= a_vld_d[r];
        a_addr_q[r] <= a_addr_d[r];
      end
      for (int unsigned c = 0; c < CP; c++) begin
        b_vld_q[c]  <= b_vld_d[c];
        b_addr_q[c] <= b_addr_d[c];
      end
      for (int unsigned r = 0; r < RP; r++) begin
        for (int unsigned c = 0; c < CP; c++) begin
          o_vld_q[r][c]  <= o_vld_d[r][c];
          o_addr_q[r][c] <= o_addr_d[r][c];
        end
      end
    end
  end

  // Fan registered state out to the per-unit ports
  always_comb begin
    instruction_ready = instr_rdy_q;
    done              = done_q;
    tiles_completed   = tiles_q;
    for (int unsigned r = 0; r < RP; r++) begin
      a_input_buffer_instruction_valids[r] = a_vld_q[r];
      a_input_buffer_address_inputs[r]     = a_addr_q[r];
      a_input_buffer_length_inputs[r]      = len_q;
      a_input_buffer_repeats_inputs[r]     = rep_q;
    end
    for (int unsigned c = 0; c < CP; c++) begin
      b_input_buffer_instruction_valids[c] = b_vld_q[c];
      b_input_buffer_address_inputs[c]     = b_addr_q[c];
      b_input_buffer_length_inputs[c]      = len_q;
      b_input_buffer_repeats_inputs[c]     = rep_q;
    end
    for (int unsigned r = 0; r < RP; r++) begin
      for (int unsigned c = 0; c < CP; c++) begin
        output_buffer_instruction_valids[r][c]  = o_vld_q[r][c];
        output_buffer_address_inputs[r][c]      = o_addr_q[r][c];
        output_buffer_by_row_instructions[r][c] = by_row_q;
        output_buffer_completed_readys[r][c]    = cmp_rdy_q;
      end
    end
  end

endmodule

// File: tb/tb_tiled_matmul_controller.sv
// Scoreboard bench for tiled_matmul_controller: directed jobs push expected
// buffer instructions; a negedge monitor pops and compares on every handshake.
module tb_tiled_matmul_controller;

  localparam int unsigned RP  = 2;
  localparam int unsigned CP  = 2;
  localparam int unsigned MAB = 64;
  localparam int unsigned MLB = 13;
  localparam int unsigned TCB = 21;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [MAB-1:0] a_base, b_base, c_base;
  logic [MLB-1:0] rows, inner, cols;
  logic           by_row, ivalid;
  logic           iready, done;
  logic [TCB-1:0] tiles;
  logic           a_v [RP];
  logic           a_r [RP];
  logic [MAB-1:0] a_ad [RP];
  logic [MLB-1:0] a_len [RP];
  logic [MLB-1:0] a_rep [RP];
  logic           b_v [CP];
  logic           b_r [CP];
  logic [MAB-1:0] b_ad [CP];
  logic [MLB-1:0] b_len [CP];
  logic [MLB-1:0] b_rep [CP];
  logic           o_v [RP][CP];
  logic           o_r [RP][CP];
  logic [MAB-1:0] o_ad [RP][CP];
  logic           o_br [RP][CP];
  logic           o_cv [RP][CP];
  logic           o_cr [RP][CP];

  logic [63:0] aq [RP][$];
  logic [63:0] bq [CP][$];
  logic [63:0] oq [RP][CP][$];
  logic [63:0] exp_len;
  logic        exp_byrow;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  tiled_matmul_controller dut (
    .clk                               (clk),
    .reset                             (rst_n),
    .a_memory_addr                     (a_base),
    .b_memory_addr                     (b_base),
    .c_memory_addr                     (c_base),
    .rows_input                        (rows),
    .inner_input                       (inner),
    .cols_input                        (cols),
    .output_by_row_input               (by_row),
    .instruction_valid                 (ivalid),
    .instruction_ready                 (iready),
    .done                              (done),
    .tiles_completed                   (tiles),
    .a_input_buffer_instruction_valids (a_v),
    .a_input_buffer_instruction_readys (a_r),
    .a_input_buffer_address_inputs     (a_ad),
    .a_input_buffer_length_inputs      (a_len),
    .a_input_buffer_repeats_inputs     (a_rep),
    .b_input_buffer_instruction_valids (b_v),
    .b_input_buffer_instruction_readys (b_r),
    .b_input_buffer_address_inputs     (b_ad),
    .b_input_buffer_length_inputs      (b_len),
    .b_input_buffer_repeats_inputs     (b_rep),
    .output_buffer_instruction_valids  (o_v),
    .output_buffer_instruction_readys  (o_r),
    .output_buffer_address_inputs      (o_ad),
    .output_buffer_by_row_instructions (o_br),
    .output_buffer_completed_valids    (o_cv),
    .output_buffer_completed_readys    (o_cr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    chk_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, want, $time);
  endtask

  function automatic int q_total();
    int s = 0;
    for (int r = 0; r < RP; r++) s += aq[r].size();
    for (int c = 0; c < CP; c++) s += bq[c].size();
    for (int r = 0; r < RP; r++)
      for (int c = 0; c < CP; c++) s += oq[r][c].size();
    return s;
  endfunction

  // Monitor: every instruction handshake must match the head of its unit's queue
  always @(negedge clk) begin
    logic [63:0] e;
    for (int r = 0; r < RP; r++) begin
      if (a_v[r] && a_r[r]) begin
        if (aq[r].size() == 0) chk($sformatf("a%0d_unexpected_valid", r), 64'(aq[r].size()), 64'd1);
        else begin
          e = aq[r].pop_front();
          chk($sformatf("a%0d_addr", r), a_ad[r], e);
          chk($sformatf("a%0d_len", r), 64'(a_len[r]), exp_len);
          chk($sformatf("a%0d_rep", r), 64'(a_rep[r]), 64'd1);
        end
      end
    end
    for (int c = 0; c < CP; c++) begin
      if (b_v[c] && b_r[c]) begin
        if (bq[c].size() == 0) chk($sformatf("b%0d_unexpected_valid", c), 64'(bq[c].size()), 64'd1);
        else begin
          e = bq[c].pop_front();
          chk($sformatf("b%0d_addr", c), b_ad[c], e);
          chk($sformatf("b%0d_len", c), 64'(b_len[c]), exp_len);
          chk($sformatf("b%0d_rep", c), 64'(b_rep[c]), 64'd1);
        end
      end
    end
    for (int r = 0; r < RP; r++) begin
      for (int c = 0; c < CP; c++) begin
        if (o_v[r][c] && o_r[r][c]) begin
          if (oq[r][c].size() == 0)
            chk($sformatf("o%0d%0d_unexpected_valid", r, c), 64'(oq[r][c].size()), 64'd1);
          else begin
            e = oq[r][c].pop_front();
            chk($sformatf("o%0d%0d_addr", r, c), o_ad[r][c], e);
            chk($sformatf("o%0d%0d_by_row", r, c), 64'(o_br[r][c]), 64'(exp_byrow));
          end
        end
      end
    end
  end

  task automatic set_readys(input logic v);
    for (int r = 0; r < RP; r++) a_r[r] = v;
    for (int c = 0; c < CP; c++) b_r[c] = v;
    for (int r = 0; r < RP; r++)
      for (int c = 0; c < CP; c++) o_r[r][c] = v;
  endtask

  task automatic start_job(input int r, input int k, input int p, input logic byr);
    @(posedge clk); #1;
    exp_len   = 64'(k);
    exp_byrow = byr;
    rows      = MLB'(r);
    inner     = MLB'(k);
    cols      = MLB'(p);
    by_row    = byr;
    ivalid    = 1'b1;
    @(posedge clk); #1;
    ivalid    = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (q_total() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 64'(q_total()), 64'd0);
  endtask

  // Pulse completed_valid for units in mask (bit r*CP+c) once readys are up
  task automatic complete(input logic [3:0] m);
    int n = 0;
    while (!o_cr[0][0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("completed_ready_timeout", 64'(o_cr[0][0]), 64'd1);
    for (int r = 0; r < RP; r++)
      for (int c = 0; c < CP; c++) o_cv[r][c] = m[r*CP+c];
    @(posedge clk); #1;
    for (int r = 0; r < RP; r++)
      for (int c = 0; c < CP; c++) o_cv[r][c] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    ivalid = 1'b0;
    by_row = 1'b0;
    rows   = '0;
    inner  = '0;
    cols   = '0;
    a_base = 64'h1000;
    b_base = 64'h2000;
    c_base = 64'h3000;
    exp_len   = 64'd0;
    exp_byrow = 1'b0;
    set_readys(1'b1);
    for (int r = 0; r < RP; r++)
      for (int c = 0; c < CP; c++) o_cv[r][c] = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iready", 64'(iready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tiles", 64'(tiles), 64'd0);
    chk("rst_a0_valid", 64'(a_v[0]), 64'd0);
    chk("rst_a0_addr", a_ad[0], 64'd0);
    chk("rst_cready", 64'(o_cr[0][0]), 64'd0);
    rst_n = 1'b1;

    // 8x8x8: single pass, completions one at a time
    aq[0].push_back(64'h1000); aq[1].push_back(64'h1020);
    bq[0].push_back(64'h2000); bq[1].push_back(64'h2020);
    oq[0][0].push_back(64'h3000); oq[0][1].push_back(64'h3004);
    oq[1][0].push_back(64'h3020); oq[1][1].push_back(64'h3024);
    start_job(8, 8, 8, 1'b1);
    chk("t1_iready_after_accept", 64'(iready), 64'd1);
    wait_empty("t1_instructions_issued");
    complete(4'b0001);
    chk("t1_tiles1", 64'(tiles), 64'd1);
    complete(4'b0010);
    complete(4'b0100);
    chk("t1_tiles3", 64'(tiles), 64'd3);
    chk("t1_done_before_last", 64'(done), 64'd0);
    complete(4'b1000);
    chk("t1_tiles4", 64'(tiles), 64'd4);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_iready_done", 64'(iready), 64'd1);

    // 12x4x4: two passes, partial unit activity
    aq[0].push_back(64'h1000); aq[1].push_back(64'h1010); aq[0].push_back(64'h1020);
    bq[0].push_back(64'h2000); bq[0].push_back(64'h2000);
    oq[0][0].push_back(64'h3000); oq[1][0].push_back(64'h3010); oq[0][0].push_back(64'h3020);
    start_job(12, 4, 4, 1'b0);
    chk("t2_done_cleared", 64'(done), 64'd0);
    chk("t2_tiles_cleared", 64'(tiles), 64'd0);
    wait_empty("t2_instructions_issued");
    complete(4'b0101);
    chk("t2_tiles2", 64'(tiles), 64'd2);
    chk("t2_done_early", 64'(done), 64'd0);
    complete(4'b0001);
    chk("t2_tiles3", 64'(tiles), 64'd3);
    chk("t2_done", 64'(done), 64'd1);

    // K=0: no instructions, done two cycles after accept
    start_job(8, 0, 8, 1'b0);
    chk("t3_iready_c1", 64'(iready), 64'd1);
    chk("t3_done_c1", 64'(done), 64'd0);
    chk("t3_tiles_c1", 64'(tiles), 64'd0);
    @(posedge clk); #1;
    chk("t3_done_c2", 64'(done), 64'd1);
    chk("t3_iready_c2", 64'(iready), 64'd1);

    // 16x16x16: four passes, A1 stalled for 10 cycles in the first pass
    aq[0].push_back(64'h1000); aq[0].push_back(64'h1000); aq[0].push_back(64'h1080); aq[0].push_back(64'h1080);
    aq[1].push_back(64'h1040); aq[1].push_back(64'h1040); aq[1].push_back(64'h10C0); aq[1].push_back(64'h10C0);
    bq[0].push_back(64'h2000); bq[0].push_back(64'h2080); bq[0].push_back(64'h2000); bq[0].push_back(64'h2080);
    bq[1].push_back(64'h2040); bq[1].push_back(64'h20C0); bq[1].push_back(64'h2040); bq[1].push_back(64'h20C0);
    oq[0][0].push_back(64'h3000); oq[0][0].push_back(64'h3008); oq[0][0].push_back(64'h3080); oq[0][0].push_back(64'h3088);
    oq[0][1].push_back(64'h3004); oq[0][1].push_back(64'h300C); oq[0][1].push_back(64'h3084); oq[0][1].push_back(64'h308C);
    oq[1][0].push_back(64'h3040); oq[1][0].push_back(64'h3048); oq[1][0].push_back(64'h30C0); oq[1][0].push_back(64'h30C8);
    oq[1][1].push_back(64'h3044); oq[1][1].push_back(64'h304C); oq[1][1].push_back(64'h30C4); oq[1][1].push_back(64'h30CC);
    a_r[1] = 1'b0;
    start_job(16, 16, 16, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_a1_held", 64'(a_v[1]), 64'd1);
    chk("t4_a1_addr_stable", a_ad[1], 64'h1040);
    chk("t4_b0_dropped", 64'(b_v[0]), 64'd0);
    chk("t4_o11_dropped", 64'(o_v[1][1]), 64'd0);
    a_r[1] = 1'b1;
    @(posedge clk); #1;
    chk("t4_pass1_a0_valid", 64'(a_v[0]), 64'd1);
    chk("t4_pass1_b0_addr", b_ad[0], 64'h2080);
    chk("t4_pass1_b1_valid", 64'(b_v[1]), 64'd1);
    wait_empty("t4_instructions_issued");
    complete(4'b1111);
    chk("t4_tiles4", 64'(tiles), 64'd4);
    complete(4'b1111);
    complete(4'b1111);
    chk("t4_tiles12", 64'(tiles), 64'd12);
    chk("t4_done_early", 64'(done), 64'd0);
    complete(4'b1111);
    chk("t4_tiles16", 64'(tiles), 64'd16);
    chk("t4_done", 64'(done), 64'd1);

    // Reset in the middle of ISSUE
    set_readys(1'b0);
    start_job(8, 8, 8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_a0_valid_pre", 64'(a_v[0]), 64'd1);
    chk("t5_o11_addr_pre", o_ad[1][1], 64'h3024);
    complete(4'b0001);
    chk("t5_tiles_pre", 64'(tiles), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_a0_valid_async", 64'(a_v[0]), 64'd0);
    chk("t5_b1_valid_async", 64'(b_v[1]), 64'd0);
    chk("t5_o11_valid_async", 64'(o_v[1][1]), 64'd0);
    chk("t5_tiles_async", 64'(tiles), 64'd0);
    chk("t5_a0_addr_async", a_ad[0], 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_readys(1'b1);
    @(posedge clk); #1;
    chk("t5_iready_after", 64'(iready), 64'd1);
    chk("t5_tiles_after", 64'(tiles), 64'd0);
    chk("t5_done_after", 64'(done), 64'd0);
    chk("t5_a0_valid_after", 64'(a_v[0]), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queues_empty", 64'(q_total()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
